// File: rtl/stream_demux4_ctrl.sv
// -----------------------------------------------------------------------------
// stream_demux4_ctrl
//
// Steering stage in front of a 1-to-4 combinational demux. A single
// valid/ready word stream is split into packets (delimited by in_last). Each
// packet is sent to one lane, and that lane is held for the whole packet. The
// lane comes from in_dest (MODE=0) or from a round-robin scan over the enabled
// lanes (MODE=1). Words pass through a one-entry output register. This gives
// one word per cycle when the selected lane's ready is held high.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake; a word is accepted when both are high
//   in_data[W-1:0]    input word
//   in_last           last word of the packet
//   in_dest[1:0]      destination lane, MODE=0, sampled on the first word
//   lane_en[3:0]      lane enable mask, sampled only at packet start
//   out_data[W-1:0]   registered word, shared by all lanes
//   out_last          registered last flag
//   out_valid[3:0]    one-hot lane valid, all zero when the register is empty
//   out_ready[3:0]    per-lane ready; only the selected lane's bit is used
//   sel[1:0]          current lane, drives the demux select
//   strobe            high when a word is held, drives the demux data input
//   busy              high while a packet is open
// -----------------------------------------------------------------------------
module stream_demux4_ctrl #(
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic [1:0]   in_dest,
    input  logic [3:0]   lane_en,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [1:0]   sel,
    output logic         strobe,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     sel_reg, sel_next;
    logic [1:0]     rr_ptr_reg, rr_ptr_next;
    logic           valid_reg, valid_next;
    logic [W-1:0]   data_reg, data_next;
    logic           last_reg, last_next;

    // Round-robin scan. The enable mask is rotated so that bit 0 is the lane
    // at rr_ptr. The lowest set bit is then the first enabled lane at or after
    // the pointer.
    logic [3:0]     rot_en;
    logic [1:0]     rr_off;
    logic [1:0]     rr_lane;
    logic           rr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_en[gi] = lane_en[rr_ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        rr_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_en[i]) begin
                rr_off = 2'(i);
            end
        end
        rr_lane = rr_ptr_reg + rr_off;
        rr_ok   = |rot_en;
    end

    // Lane proposed for a packet that starts this cycle.
    logic [1:0] pick_lane;
    logic       pick_ok;

    assign pick_lane = (MODE == 1) ? rr_lane : in_dest;
    assign pick_ok   = (MODE == 1) ? rr_ok   : lane_en[in_dest];

    // In BUSY the lane is locked, so in_dest and lane_en no longer matter.
    logic       lane_ok;
    logic [1:0] lane_now;
    logic       drain_ok;
    logic       accept;

    assign lane_ok  = (state_reg == BUSY) ? 1'b1    : pick_ok;
    assign lane_now = (state_reg == BUSY) ? sel_reg : pick_lane;
    // The register can take a new word if it is empty, or if the word it
    // holds leaves on this same edge.
    assign drain_ok = !valid_reg || out_ready[sel_reg];
    assign in_ready = lane_ok && drain_ok;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        valid_next  = valid_reg;
        data_next   = data_reg;
        last_next   = last_reg;

        if (accept) begin
            valid_next = 1'b1;
            data_next  = in_data;
            last_next  = in_last;
            // sel changes only on an accept. An accept with a word still held
            // needs that word to be draining, so sel cannot move under a
            // stalled word.
            sel_next   = lane_now;
            if (in_last) begin
                state_next = IDLE;
                if (MODE == 1) begin
                    rr_ptr_next = lane_now + 2'd1;
                end
            end else begin
                state_next = BUSY;
            end
        end else if (valid_reg && out_ready[sel_reg]) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sel_reg    <= 2'd0;
            rr_ptr_reg <= 2'd0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            last_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
            valid_reg  <= valid_next;
            data_reg   <= data_next;
            last_reg   <= last_next;
        end
    end

    assign out_data  = data_reg;
    assign out_last  = last_reg;
    assign out_valid = valid_reg ? (4'b0001 << sel_reg) : 4'b0000;
    assign sel       = sel_reg;
    assign strobe    = valid_reg;
    assign busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_stream_demux4_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stream_demux4_ctrl
//
// Directed testbench for stream_demux4_ctrl. It uses two instances: u0 takes
// its lane from in_dest (MODE=0), and u1 uses round-robin (MODE=1). The two
// instances share the data-side inputs, and each has its own in_valid.
// Inputs change 1 time unit after the rising edge. Registered outputs are
// checked at that same point. Combinational in_ready is checked 1 time unit
// after that.
// -----------------------------------------------------------------------------
module tb_stream_demux4_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [1:0]   in_dest;
    logic [3:0]   lane_en;
    logic [3:0]   out_ready;

    logic         iv0, ir0, ol0, strb0, busy0;
    logic [W-1:0] od0;
    logic [3:0]   ov0;
    logic [1:0]   sel0;

    logic         iv1, ir1, ol1, strb1, busy1;
    logic [W-1:0] od1;
    logic [3:0]   ov1;
    logic [1:0]   sel1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux4_ctrl #(.W(W), .MODE(0)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0), .in_data(in_data), .in_last(in_last),
        .in_dest(in_dest), .lane_en(lane_en),
        .out_data(od0), .out_last(ol0), .out_valid(ov0), .out_ready(out_ready),
        .sel(sel0), .strobe(strb0), .busy(busy0)
    );

    stream_demux4_ctrl #(.W(W), .MODE(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_data(in_data), .in_last(in_last),
        .in_dest(in_dest), .lane_en(lane_en),
        .out_data(od1), .out_last(ol1), .out_valid(ov1), .out_ready(out_ready),
        .sel(sel1), .strobe(strb1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
        in_data = '0; in_last = 1'b0; in_dest = 2'd0;
        lane_en = 4'b1111; out_ready = 4'b1111;
        tick(); tick();
        chk("rst_ov0", ov0, 4'b0000);
        chk("rst_od0", od0, 8'h00);
        chk("rst_ol0", ol0, 1'b0);
        chk("rst_sel0", sel0, 2'd0);
        chk("rst_strb0", strb0, 1'b0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_ov1", ov1, 4'b0000);
        chk("rst_busy1", busy1, 1'b0);
        rst = 1'b0;
        tick();

        // MODE=0: 3-word packet to lane 2, then a 1-word packet to lane 0.
        iv0 = 1'b1; in_data = 8'hA1; in_dest = 2'd2; in_last = 1'b0;
        #1 chk("t1_ir_a1", ir0, 1'b1);
        tick();
        chk("t1_ov_a1", ov0, 4'b0100);
        chk("t1_od_a1", od0, 8'hA1);
        chk("t1_busy_a1", busy0, 1'b1);
        chk("t1_strb_a1", strb0, 1'b1);
        in_data = 8'hA2; in_dest = 2'd0;
        tick();
        chk("t1_ov_a2", ov0, 4'b0100);
        chk("t1_od_a2", od0, 8'hA2);
        chk("t1_ol_a2", ol0, 1'b0);
        in_data = 8'hA3; in_last = 1'b1;
        tick();
        chk("t1_ov_a3", ov0, 4'b0100);
        chk("t1_od_a3", od0, 8'hA3);
        chk("t1_ol_a3", ol0, 1'b1);
        in_data = 8'hB1; in_dest = 2'd0; in_last = 1'b1;
        #1 chk("t1_ir_b1", ir0, 1'b1);
        tick();
        chk("t1_ov_b1", ov0, 4'b0001);
        chk("t1_od_b1", od0, 8'hB1);
        chk("t1_ol_b1", ol0, 1'b1);
        chk("t1_busy_b1", busy0, 1'b0);
        iv0 = 1'b0;
        tick();
        chk("t1_ov_empty", ov0, 4'b0000);

        // Back-pressure on lane 1. The other lanes stay ready and must not
        // affect the held word.
        iv0 = 1'b1; in_data = 8'h5A; in_dest = 2'd1; in_last = 1'b1;
        out_ready = 4'b1101;
        tick();
        chk("t2_ov_5a", ov0, 4'b0010);
        chk("t2_od_5a", od0, 8'h5A);
        in_data = 8'h77; in_dest = 2'd3;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t2_ir_hold%0d", i), ir0, 1'b0);
            tick();
            chk($sformatf("t2_od_hold%0d", i), od0, 8'h5A);
            chk($sformatf("t2_ov_hold%0d", i), ov0, 4'b0010);
            chk($sformatf("t2_sel_hold%0d", i), sel0, 2'd1);
        end
        iv0 = 1'b0; out_ready = 4'b1111;
        tick();
        chk("t2_ov_drained", ov0, 4'b0000);

        // MODE=0 stall: the destination lane is disabled.
        iv0 = 1'b1; in_data = 8'hC1; in_dest = 2'd2; lane_en = 4'b1011;
        #1 chk("t2b_ir_stall", ir0, 1'b0);
        tick();
        chk("t2b_ov_stall", ov0, 4'b0000);
        iv0 = 1'b0; lane_en = 4'b1111;

        // MODE=1 round-robin with lane_en=1011: lanes 0,1,3,0.
        iv1 = 1'b1; in_last = 1'b1; lane_en = 4'b1011; in_data = 8'h11;
        tick();
        chk("t3_sel_p1", sel1, 2'd0);
        chk("t3_ov_p1", ov1, 4'b0001);
        chk("t3_od_p1", od1, 8'h11);
        in_data = 8'h12;
        tick();
        chk("t3_sel_p2", sel1, 2'd1);
        chk("t3_ov_p2", ov1, 4'b0010);
        in_data = 8'h13;
        tick();
        chk("t3_sel_p3", sel1, 2'd3);
        chk("t3_ov_p3", ov1, 4'b1000);
        in_data = 8'h14;
        tick();
        chk("t3_sel_p4", sel1, 2'd0);
        chk("t3_ov_p4", ov1, 4'b0001);
        chk("t3_od_p4", od1, 8'h14);
        iv1 = 1'b0;
        tick();
        chk("t3_ov_empty", ov1, 4'b0000);

        // No lane enabled: stall until lane 2 is enabled.
        iv1 = 1'b1; lane_en = 4'b0000; in_data = 8'h2C;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("t4_ir_stall%0d", i), ir1, 1'b0);
            tick();
            chk($sformatf("t4_ov_stall%0d", i), ov1, 4'b0000);
        end
        lane_en = 4'b0100;
        #1 chk("t4_ir_go", ir1, 1'b1);
        tick();
        chk("t4_sel", sel1, 2'd2);
        chk("t4_ov", ov1, 4'b0100);
        chk("t4_od", od1, 8'h2C);
        iv1 = 1'b0;
        tick();

        // Mid-packet changes to in_dest and lane_en are ignored.
        lane_en = 4'b1111; iv0 = 1'b1; in_dest = 2'd1; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h31 + 8'(i);
            in_last = (i == 3);
            tick();
            chk($sformatf("t5_sel_w%0d", i), sel0, 2'd1);
            chk($sformatf("t5_ov_w%0d", i), ov0, 4'b0010);
            chk($sformatf("t5_od_w%0d", i), od0, 8'h31 + 8'(i));
            in_dest = 2'd3; lane_en = 4'b0001;
        end
        chk("t5_busy_end", busy0, 1'b0);
        iv0 = 1'b0; lane_en = 4'b1111;
        tick();

        // Reset while BUSY with a word held.
        iv0 = 1'b1; in_data = 8'h66; in_dest = 2'd3; in_last = 1'b0;
        out_ready = 4'b0000;
        tick();
        chk("t6_busy_pre", busy0, 1'b1);
        chk("t6_ov_pre", ov0, 4'b1000);
        iv0 = 1'b0; rst = 1'b1;
        tick();
        chk("t6_ov_rst", ov0, 4'b0000);
        chk("t6_busy_rst", busy0, 1'b0);
        chk("t6_od_rst", od0, 8'h00);
        chk("t6_sel_rst", sel0, 2'd0);
        rst = 1'b0; out_ready = 4'b1111;
        iv0 = 1'b1; in_data = 8'h99; in_dest = 2'd0; in_last = 1'b1;
        #1 chk("t6_ir_new", ir0, 1'b1);
        tick();
        chk("t6_ov_new", ov0, 4'b0001);
        chk("t6_od_new", od0, 8'h99);
        chk("t6_busy_new", busy0, 1'b0);
        iv0 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
